pio_poll_master: RTL and testbench

- Avalon-MM initiator that drives the read side of a 1-bit input PIO slave (s1: 2-bit address, 32-bit readdata, fixed read latency).
- Polls address 0 periodically and captures bit 0 as the input level.
- Produces debounced-by-sampling level, rise/fall event pulses and a saturating change counter for fabric logic that must not use a CPU.
- Sits between the PIO slave and local control logic in the same Qsys-generated system.

---
 rtl/pio_poll_pkg.sv | 23 ++
 rtl/pio_edge_detect.sv | 63 ++++++
 rtl/pio_poll_master.sv | 106 ++++++++++
 tb/tb_pio_poll_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_poll_pkg.sv
// Shared definitions for the PIO polling initiator: FSM encoding, slave
// address map and the legal parameter ranges.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LAT  = 2'd2,
    ST_WAIT = 2'd3
  } poll_state_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  localparam int POLL_INTERVAL_MIN = 1;
  localparam int POLL_INTERVAL_MAX = 65535;
  localparam int READ_LATENCY_MIN  = 1;
  localparam int READ_LATENCY_MAX  = 4;

  // Timer widths sized for the largest legal parameter value.
  localparam int IVL_W = 16;
  localparam int LAT_W = 2;

endpackage

// File: rtl/pio_edge_detect.sv
// Sampled-level tracker: holds the last captured bit, flags validity and
// emits rise/fall pulses plus a saturating transition count.
module pio_edge_detect #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap_i,
  input  logic             bit_i,
  output logic             level_o,
  output logic             level_valid_o,
  output logic             rise_pulse_o,
  output logic             fall_pulse_o,
  output logic [CNT_W-1:0] change_count_o
);

  logic             level_q, level_d;
  logic             valid_q, valid_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    valid_d = valid_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    if (cap_i) begin
      level_d = bit_i;
      valid_d = 1'b1;
      // The very first sample only establishes the reference level.
      if (valid_q && (bit_i != level_q)) begin
        rise_d = bit_i;
        fall_d = ~bit_i;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o        = level_q;
  assign level_valid_o  = valid_q;
  assign rise_pulse_o   = rise_q;
  assign fall_pulse_o   = fall_q;
  assign change_count_o = cnt_q;

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that periodically polls a 1-bit PIO and turns the
// sampled input into level, edge pulses and a change count.
//
// state | meaning
// IDLE  | polling disabled, no transaction outstanding
// READ  | avm_read asserted, waiting for waitrequest low
// LAT   | command accepted, counting down the fixed read latency
// WAIT  | interval timer running until the next poll
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int POLL_INTERVAL = 1024,
  parameter int READ_LATENCY  = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic             level,
  output logic             level_valid,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] change_count,
  output logic             busy
);

  localparam logic [IVL_W-1:0] IVL_INIT = IVL_W'(POLL_INTERVAL - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

  poll_state_e      state_q, state_d;
  logic [IVL_W-1:0] ivl_q, ivl_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             cap;
  logic             unused_rd_hi;

  always_comb begin
    state_d = state_q;
    ivl_d   = ivl_q;
    lat_d   = lat_q;
    cap     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_READ;
      ST_READ: begin
        if (!avm_waitrequest) begin
          state_d = ST_LAT;
          lat_d   = LAT_INIT;
        end
      end
      ST_LAT: begin
        // An accepted read always completes, even if enable has dropped.
        if (lat_q == '0) begin
          cap     = 1'b1;
          ivl_d   = IVL_INIT;
          state_d = enable ? ST_WAIT : ST_IDLE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          ivl_d   = '0;
        end else if (ivl_q == '0) begin
          state_d = ST_READ;
        end else begin
          ivl_d = ivl_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ivl_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      ivl_q   <= ivl_d;
      lat_q   <= lat_d;
    end
  end

  assign avm_address  = PIO_DATA_ADDR;
  assign avm_read     = (state_q == ST_READ);
  assign busy         = (state_q != ST_IDLE);
  assign unused_rd_hi = ^avm_readdata[31:1];

  pio_edge_detect #(.CNT_W(CNT_W)) u_edge (
    .clk            (clk),
    .reset          (reset),
    .cap_i          (cap),
    .bit_i          (avm_readdata[0]),
    .level_o        (level),
    .level_valid_o  (level_valid),
    .rise_pulse_o   (rise_pulse),
    .fall_pulse_o   (fall_pulse),
    .change_count_o (change_count)
  );

endmodule

// File: tb/tb_pio_poll_master.sv
// Bench for pio_poll_master: scoreboard predicts each capture when the read
// is accepted and checks the outputs once the capture is due.
module tb_pio_poll_master;

  localparam int PI    = 4;
  localparam int RL    = 1;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [1:0]       avm_address;
  logic             avm_read;
  logic             avm_waitrequest = 1'b0;
  logic [31:0]      avm_readdata;
  logic             level, level_valid, rise_pulse, fall_pulse, busy;
  logic [CNT_W-1:0] change_count;
  logic             in_port = 1'b0;
  logic [31:0]      rd_hi = '0;

  typedef struct packed {
    logic             level;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb_q[$];
  int               vec_cnt = 0;
  int               err_cnt = 0;
  int               acc_cnt = 0;
  int               cap_cnt = 0;
  int               due = 0;
  logic             m_valid = 1'b0;
  logic             m_level = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  always #5 clk = ~clk;

  assign avm_readdata = {rd_hi[30:0], in_port};
  always @(posedge clk) rd_hi <= $urandom;

  pio_poll_master #(.POLL_INTERVAL(PI), .READ_LATENCY(RL), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .level           (level),
    .level_valid     (level_valid),
    .rise_pulse      (rise_pulse),
    .fall_pulse      (fall_pulse),
    .change_count    (change_count),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: predict on acceptance, compare RL+1 negedges later.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb_q.delete();
      due     = 0;
      m_valid = 1'b0;
      m_level = 1'b0;
      m_cnt   = '0;
    end else begin
      if (due > 0) begin
        due--;
        if (due == 0) begin
          e = sb_q.pop_front();
          check("level", level, e.level);
          check("level_valid", level_valid, 1);
          check("rise", rise_pulse, e.rise);
          check("fall", fall_pulse, e.fall);
          check("count", change_count, e.cnt);
          cap_cnt++;
        end
      end else begin
        check("no_pulse", {rise_pulse, fall_pulse}, 2'b00);
      end
      if (avm_read && !avm_waitrequest) begin
        check("addr", avm_address, 0);
        e.level = in_port;
        e.rise  = m_valid && in_port && !m_level;
        e.fall  = m_valid && !in_port && m_level;
        if (m_valid && (in_port != m_level) && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
        e.cnt   = m_cnt;
        m_valid = 1'b1;
        m_level = in_port;
        sb_q.push_back(e);
        acc_cnt++;
        due = RL + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_capture(input int target);
    for (int i = 0; i < 200; i++) begin
      step();
      if (cap_cnt >= target) return;
    end
    check("capture_timeout", cap_cnt, target);
  endtask

  task automatic wait_read();
    for (int i = 0; i < 100; i++) begin
      step();
      if (avm_read) return;
    end
    check("read_timeout", avm_read, 1);
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;

    // Idle with polling disabled.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_read", avm_read, 0);
      check("idle_outs", {level, level_valid, rise_pulse, fall_pulse, busy}, 0);
      check("idle_count", change_count, 0);
      check("idle_addr", avm_address, 0);
    end

    // Steady input of 1: reads in cycles 1, 7, 13.
    step();
    in_port = 1'b1;
    enable  = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check($sformatf("period_read_c%0d", k), avm_read, (k == 1 || k == 7 || k == 13));
      check($sformatf("valid_c%0d", k), level_valid, (k >= 3));
      if (k >= 3) check($sformatf("level_c%0d", k), level, 1);
    end

    // Toggles between polls produce single pulses and counts.
    step();
    in_port = 1'b0;
    wait_capture(acc_cnt + 1);
    in_port = 1'b1;
    wait_capture(acc_cnt + 1);
    in_port = 1'b0;
    wait_capture(acc_cnt + 1);
    check("count_after_toggles", change_count, 3);

    // Five stall cycles stretch the read command to six cycles.
    avm_waitrequest = 1'b1;
    in_port = 1'b1;
    wait_read();
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_read_held", avm_read, 1);
    end
    step();
    avm_waitrequest = 1'b0;
    check("stall_read_last", avm_read, 1);
    step();
    check("stall_lat_read", avm_read, 0);
    check("stall_lat_busy", busy, 1);
    wait_capture(acc_cnt);

    // enable dropped during LAT: sample lands, then no further reads.
    in_port = 1'b0;
    wait_read();
    step();
    check("lat_state", {avm_read, busy}, 2'b01);
    enable = 1'b0;
    wait_capture(acc_cnt);
    check("lat_drop_level", level, 0);
    check("lat_drop_busy", busy, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      check("lat_drop_no_read", avm_read, 0);
    end

    // enable dropped during WAIT: IDLE on the next cycle.
    enable = 1'b1;
    wait_capture(acc_cnt + 1);
    check("wait_busy", busy, 1);
    enable = 1'b0;
    step();
    check("wait_drop_busy", busy, 0);
    check("wait_drop_read", avm_read, 0);

    // Twenty transitions saturate the counter.
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_port = ~in_port;
      wait_capture(acc_cnt + 1);
    end
    check("count_saturated", change_count, 15);

    // Reset in the middle of a stalled read.
    avm_waitrequest = 1'b1;
    wait_read();
    #2;
    reset = 1'b1;
    #1;
    check("rst_read", avm_read, 0);
    check("rst_outs", {level, level_valid, rise_pulse, fall_pulse, busy}, 0);
    check("rst_count", change_count, 0);
    avm_waitrequest = 1'b0;
    step();
    reset = 1'b0;

    // First capture after reset: valid, no pulse, no count.
    in_port = 1'b1;
    wait_capture(acc_cnt + 1);
    check("post_rst_count", change_count, 0);
    enable = 1'b0;
    repeat (10) step();
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
